muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer for the EX-stage multiply/divide resources and the HI/LO write port.
- Accepts one mult/multu/div/divu/mthi/mtlo operation per instruction from EX.
- Drives the pipelined multiplier (fixed latency) and the iterative divider (start/ready handshake).
- Holds the pipeline via stallreq until the result is ready, then issues a single HI/LO write pulse.
- Supports annul on flush.

Parameters:
- MUL_LATENCY, 2, cycles from mul_en to a valid mul_result; legal range 1..7.
- CNT_W, 3, width of the multiplier latency counter; must satisfy 2^CNT_W > MUL_LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- op_valid  in  1  EX holds a valid mul/div/mt operation
- op_type  in  3  operation code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6
- src_a  in  32  rs operand (dividend / multiplicand / mt data)
- src_b  in  32  rt operand (divisor / multiplier)
- annul  in  1  flush: abort the current operation
- stallreq  out  1  hold IF..EX
- busy  out  1  state != IDLE
- hi_we / lo_we  out  1  HI / LO write pulses
- hi_wdata / lo_wdata  out  32  HI / LO write data
- mul_en  out  1  operands valid for the multiplier, one-cycle pulse
- mul_signed  out  1  signed multiply
- mul_opa / mul_opb  out  32  multiplier operands
- mul_result  in  64  {hi,lo}; valid MUL_LATENCY cycles after mul_en
- div_start  out  1  divider start, level, held until ready
- div_signed  out  1  signed divide
- div_opa / div_opb  out  32  divider operands
- div_annul  out  1  abort the divider
- div_ready  in  1  divider result valid, one-cycle pulse
- div_result  in  64  {remainder,quotient}

Behaviour:
- Reset: state IDLE; all outputs 0; latched operands and counter cleared. Reset mid-operation returns to IDLE next edge with no HI/LO write.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE, op MTHI/MTLO: hi_we (or lo_we) asserted combinationally in the same cycle with wdata = src_a. No stall, stay in IDLE.
- IDLE, op MULT/MULTU: latch operands and signedness; mul_en=1 this cycle; counter = MUL_LATENCY-1; stallreq=1 combinationally; go to MUL_WAIT.
- MUL_WAIT: stallreq=1; counter decrements each cycle. At counter==0, capture mul_result into the result register and go to DONE.
- IDLE, op DIV/DIVU, src_b != 0: latch operands; stallreq=1 combinationally; go to DIV_WAIT.
- DIV_WAIT: div_start=1 with the latched operands; stallreq=1. On div_ready, capture HI=div_result[63:32], LO=div_result[31:0], drop div_start the next cycle, go to DONE.
- Divide by zero (src_b==0): bypass the divider; HI=src_a, LO=32'hFFFF_FFFF; go to DONE next cycle; stallreq=1 for that one cycle.
- DONE: hi_we=lo_we=1 with registered data for exactly one cycle; stallreq=0 so EX advances; op_valid is ignored (same instruction still present); go to IDLE.
- annul (any state except DONE): next state IDLE, no HI/LO write. div_annul=1 for one cycle if leaving DIV_WAIT. Any mul_result still in flight is discarded. annul in IDLE blocks acceptance that cycle.
- annul during DONE: the write still completes (the instruction has already committed).
- stallreq is combinational from state and op decode; all other control outputs are registered except the IDLE mt path and the IDLE-cycle mul_en.
- Signedness: MULT/DIV signed; MULTU/DIVU unsigned. The divider computes sign fix-up internally.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, a MULT/MULTU with src_a==0 or src_b==0 goes straight to DONE with result 64'h0, and a DIV/DIVU with src_a==0 (src_b!=0) goes to DONE with HI=LO=0. Neither unit is started; stallreq is asserted for 1 cycle.
- Undefined: all multiplies and divides take the normal path.

Decomposition:
- Shared package/defines: op_type encodings, state encodings, Stop/NoStop, the div-by-zero LO constant.
- One natural sub-module: muldiv_lat_cnt (loadable down-counter with zero flag), used for MUL_WAIT.

Test Plan:
1. MULT src_a=32'hFFFF_FFFE (-2), src_b=3, MUL_LATENCY=2 -> stallreq high for 3 cycles. The DONE cycle follows, with hi_wdata=32'hFFFF_FFFF, lo_wdata=32'hFFFF_FFFA, and hi_we/lo_we high for 1 cycle.
2. DIVU 100/7 with div_ready after 33 cycles -> div_start held 33 cycles. DONE writes HI=2, LO=14. No restart on the same op_valid in DONE.
3. DIV src_b=0, src_a=5 -> div_start never asserted. stallreq for 1 cycle, then HI=5, LO=32'hFFFF_FFFF.
4. annul asserted on the 10th DIV_WAIT cycle -> div_annul pulse, IDLE next cycle, hi_we/lo_we stay 0.
5. MTHI src_a=32'h1234_5678 -> hi_we=1 in the same cycle, hi_wdata=32'h1234_5678, stallreq=0, lo_we=0.
6. rst asserted in MUL_WAIT -> all outputs 0 next cycle. A subsequent MULTU 3*4 yields LO=12, HI=0.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [DATA_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable down-counter with zero flag; tracks the multiplier pipeline latency.
module muldiv_lat_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: drives the pipelined multiplier and iterative divider,
// stalls EX until done, then writes HI/LO once. Build option: MULDIV_EARLY_OUT_EN.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [2:0]          op_type,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    input  logic                annul,
    output logic                stallreq,
    output logic                busy,
    output logic                hi_we,
    output logic                lo_we,
    output logic [DATA_W-1:0]   hi_wdata,
    output logic [DATA_W-1:0]   lo_wdata,
    output logic                mul_en,
    output logic                mul_signed,
    output logic [DATA_W-1:0]   mul_opa,
    output logic [DATA_W-1:0]   mul_opb,
    input  logic [2*DATA_W-1:0] mul_result,
    output logic                div_start,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_opa,
    output logic [DATA_W-1:0]   div_opb,
    output logic                div_annul,
    input  logic                div_ready,
    input  logic [2*DATA_W-1:0] div_result
);

    state_t state, state_nxt;
    op_t    op;
    logic   accept, is_mul, is_div, early_out;
    logic   cnt_load, cnt_zero_c;

    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] mul_opa_q, mul_opb_q, div_opa_q, div_opb_q;
    logic              mul_sgn_q, div_sgn_q, busy_q, div_start_q, div_annul_q;

    assign op     = op_t'(op_type);
    assign accept = (state == ST_IDLE) && op_valid && !annul;
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

`ifdef MULDIV_EARLY_OUT_EN
    // Trivially-zero products and zero dividends skip both units.
    assign early_out = (is_mul && ((src_a == '0) || (src_b == '0))) ||
                       (is_div && (src_a == '0) && (src_b != '0));
`else
    assign early_out = 1'b0;
`endif

    muldiv_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(MUL_LATENCY - 1)),
        .dec      (state == ST_MUL_WAIT),
        .zero_c   (cnt_zero_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the combinational outputs (stall, IDLE mt writes, mul_en).
    always_comb begin
        state_nxt = state;
        stallreq  = NO_STOP;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_wdata  = '0;
        lo_wdata  = '0;
        mul_en    = 1'b0;
        cnt_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MTHI: begin
                            hi_we    = 1'b1;
                            hi_wdata = src_a;
                        end
                        OP_MTLO: begin
                            lo_we    = 1'b1;
                            lo_wdata = src_a;
                        end
                        OP_MULT, OP_MULTU: begin
                            stallreq = STOP;
                            if (early_out) begin
                                state_nxt = ST_DONE;
                            end else begin
                                mul_en    = 1'b1;
                                cnt_load  = 1'b1;
                                state_nxt = ST_MUL_WAIT;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            stallreq  = STOP;
                            state_nxt = ((src_b == '0) || early_out) ? ST_DONE : ST_DIV_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                stallreq = STOP;
                if (annul)           state_nxt = ST_IDLE;
                else if (cnt_zero_c) state_nxt = ST_DONE;
            end
            ST_DIV_WAIT: begin
                stallreq = STOP;
                if (annul)          state_nxt = ST_IDLE;
                else if (div_ready) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Instruction has committed: write regardless of annul or op_valid.
                hi_we     = 1'b1;
                lo_we     = 1'b1;
                hi_wdata  = hi_q;
                lo_wdata  = lo_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered control, latched operands and the HI/LO result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            div_annul_q <= 1'b0;
            mul_opa_q   <= '0;
            mul_opb_q   <= '0;
            mul_sgn_q   <= 1'b0;
            div_opa_q   <= '0;
            div_opb_q   <= '0;
            div_sgn_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            busy_q      <= (state_nxt != ST_IDLE);
            div_start_q <= (state_nxt == ST_DIV_WAIT);
            div_annul_q <= (state == ST_DIV_WAIT) && annul;
            if (mul_en) begin
                mul_opa_q <= src_a;
                mul_opb_q <= src_b;
                mul_sgn_q <= op_is_signed(op);
            end
            if ((state == ST_IDLE) && (state_nxt == ST_DIV_WAIT)) begin
                div_opa_q <= src_a;
                div_opb_q <= src_b;
                div_sgn_q <= op_is_signed(op);
            end
            if (state_nxt == ST_DONE) begin
                case (state)
                    ST_IDLE: begin
                        if (early_out) begin
                            hi_q <= '0;
                            lo_q <= '0;
                        end else begin
                            hi_q <= src_a;
                            lo_q <= DIV_ZERO_LO;
                        end
                    end
                    ST_MUL_WAIT: {hi_q, lo_q} <= mul_result;
                    ST_DIV_WAIT: {hi_q, lo_q} <= div_result;
                    default: ;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign mul_signed = mul_en ? op_is_signed(op) : mul_sgn_q;
    assign mul_opa    = mul_en ? src_a : mul_opa_q;
    assign mul_opb    = mul_en ? src_b : mul_opb_q;
    assign div_start  = div_start_q;
    assign div_signed = div_sgn_q;
    assign div_opa    = div_opa_q;
    assign div_opb    = div_opb_q;
    assign div_annul  = div_annul_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural multiplier and divider models.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int unsigned MUL_LAT = 2;
    localparam int          DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        rst, op_valid, annul;
    logic [2:0]  op_type;
    logic [31:0] src_a, src_b;
    logic        stallreq, busy, hi_we, lo_we, mul_en, mul_signed;
    logic [31:0] hi_wdata, lo_wdata, mul_opa, mul_opb, div_opa, div_opb;
    logic [63:0] mul_result, div_result;
    logic        div_start, div_signed, div_annul, div_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
        .src_a(src_a), .src_b(src_b), .annul(annul),
        .stallreq(stallreq), .busy(busy), .hi_we(hi_we), .lo_we(lo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .mul_en(mul_en), .mul_signed(mul_signed), .mul_opa(mul_opa), .mul_opb(mul_opb),
        .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
        .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result)
    );

    // Multiplier model: result visible only in the cycle MUL_LAT after mul_en.
    logic [63:0] ea, eb, prod;
    logic [63:0] mstage [MUL_LAT];
    always_comb begin
        ea   = mul_signed ? {{32{mul_opa[31]}}, mul_opa} : {32'h0, mul_opa};
        eb   = mul_signed ? {{32{mul_opb[31]}}, mul_opb} : {32'h0, mul_opb};
        prod = ea * eb;
    end
    always_ff @(posedge clk) begin
        mstage[0] <= mul_en ? prod : 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 1; i < int'(MUL_LAT); i++) mstage[i] <= mstage[i-1];
    end
    assign mul_result = mstage[MUL_LAT-1];

    // Divider model: ready pulses on the DIV_CYC-th consecutive cycle of div_start.
    int dcnt = 0;
    logic signed [31:0] sq, sr;
    always_ff @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;
    assign div_ready = div_start && (dcnt == DIV_CYC - 1);
    always_comb begin
        sq = '0;
        sr = '0;
        div_result = '0;
        if (div_opb != 0) begin
            if (div_signed) begin
                sq = $signed(div_opa) / $signed(div_opb);
                sr = $signed(div_opa) % $signed(div_opb);
                div_result = {sr, sq};
            end else begin
                div_result = {div_opa % div_opb, div_opa / div_opb};
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        int          stalls, dst, men;
        logic        hwe, lwe;
        logic [31:0] hi, lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_valid = v;
        op_type  = op;
        src_a    = a;
        src_b    = b;
    endtask

    // Runs one op to its HI/LO write; entered and left at posedge+1.
    task automatic run_op(input vec_t v, input string name);
        int  stalls = 0, dst = 0, men = 0;
        bit  done = 0;
        drive(1'b1, v.op, v.a, v.b);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (div_start) dst++;
            if (mul_en) men++;
            if (hi_we || lo_we) begin
                done = 1;
                check({name, " we"}, 64'({hi_we, lo_we}), 64'({v.hwe, v.lwe}));
                if (v.hwe) check({name, " hi"}, 64'(hi_wdata), 64'(v.hi));
                if (v.lwe) check({name, " lo"}, 64'(lo_wdata), 64'(v.lo));
                check({name, " busy"}, 64'(busy), 64'(v.stalls != 0));
            end else if (stallreq) begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        if (!done) check({name, " timeout"}, 64'(0), 64'(1));
        check({name, " stalls"}, 64'(stalls), 64'(v.stalls));
        check({name, " div_start cycles"}, 64'(dst), 64'(v.dst));
        check({name, " mul_en pulses"}, 64'(men), 64'(v.men));
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        check({name, " post idle"}, 64'({hi_we, lo_we, busy, stallreq, div_start}), 64'(0));
        @(posedge clk); #1;
    endtask

    vec_t tv [11];
    vec_t v3x4;

    initial begin
        tv[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        3,  0,  1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tv[1]  = '{OP_DIVU,  32'd100,       32'd7,        34, 33, 0, 1'b1, 1'b1, 32'd2,         32'd14};
        tv[2]  = '{OP_DIV,   32'd5,         32'd0,        1,  0,  0, 1'b1, 1'b1, 32'd5,         32'hFFFF_FFFF};
        tv[3]  = '{OP_MTHI,  32'h1234_5678, 32'h0,        0,  0,  0, 1'b1, 1'b0, 32'h1234_5678, 32'h0};
        tv[4]  = '{OP_MTLO,  32'hCAFE_BABE, 32'h0,        0,  0,  0, 1'b0, 1'b1, 32'h0,         32'hCAFE_BABE};
        tv[5]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0,  1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
        tv[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        34, 33, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tv[7]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 3, 0,  1, 1'b1, 1'b1, 32'hC000_0000, 32'h8000_0000};
        tv[8]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h10,       34, 33, 0, 1'b1, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF};
        tv[9]  = '{OP_DIVU,  32'd0,         32'd3,        34, 33, 0, 1'b1, 1'b1, 32'd0,         32'd0};
        tv[10] = '{OP_MULT,  32'd0,         32'd5,        3,  0,  1, 1'b1, 1'b1, 32'd0,         32'd0};
        v3x4   = '{OP_MULTU, 32'd3,         32'd4,        3,  0,  1, 1'b1, 1'b1, 32'd0,         32'd12};

        rst   = 1'b1;
        annul = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", 64'({stallreq, busy, hi_we, lo_we, mul_en, mul_signed,
                                 div_start, div_signed, div_annul}), 64'(0));
        check("reset data", {hi_wdata | lo_wdata | mul_opa | mul_opb, div_opa | div_opb}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op(tv[i], $sformatf("vec%0d", i));

        // annul on the 10th DIV_WAIT cycle
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        annul = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("dw10 div ops", {div_opa, div_opb}, {32'd100, 32'd7});
        check("dw10 ctrl", 64'({div_start, div_signed, stallreq}), 64'(3'b111));
        @(posedge clk); #1;
        annul = 1'b0;
        @(negedge clk);
        check("div annul pulse", 64'({div_annul, div_start, busy, hi_we, lo_we}), 64'(5'b10000));
        @(posedge clk); #1;
        @(negedge clk);
        check("div annul after", 64'({div_annul, hi_we, lo_we, busy}), 64'(0));
        @(posedge clk); #1;

        // annul in MUL_WAIT discards the in-flight product
        drive(1'b1, OP_MULT, 32'd7, 32'd9);
        @(posedge clk); #1;
        annul = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        annul = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mul annul quiet", 64'({hi_we, lo_we, busy, stallreq}), 64'(0));
            @(posedge clk); #1;
        end

        // annul in IDLE blocks acceptance
        annul = 1'b1;
        drive(1'b1, OP_MTHI, 32'h5555_AAAA, 32'h0);
        @(negedge clk);
        check("idle annul mthi", 64'({hi_we, lo_we, stallreq}), 64'(0));
        @(posedge clk); #1;
        drive(1'b1, OP_MULT, 32'd2, 32'd2);
        @(negedge clk);
        check("idle annul mult", 64'({mul_en, stallreq}), 64'(0));
        @(posedge clk); #1;
        annul = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("idle annul busy", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // annul during DONE: write still completes
        drive(1'b1, OP_MULTU, 32'd6, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(negedge clk);
        check("done annul write", {31'h0, hi_we, lo_we, lo_wdata}, {31'h0, 1'b1, 1'b1, 32'd42});
        @(posedge clk); #1;
        annul = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("done annul after", 64'({hi_we, lo_we, busy}), 64'(0));
        @(posedge clk); #1;

        // reset in MUL_WAIT
        drive(1'b1, OP_MULT, 32'd7, 32'd9);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("mw reset ctrl", 64'({stallreq, busy, hi_we, lo_we, mul_en, mul_signed,
                                    div_start, div_signed, div_annul}), 64'(0));
        check("mw reset data", {hi_wdata | lo_wdata | mul_opa | mul_opb, div_opa | div_opb}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mw reset quiet", 64'({hi_we, lo_we, busy}), 64'(0));
            @(posedge clk); #1;
        end
        run_op(v3x4, "multu 3x4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
